crc_mc: RTL

Multi-channel, parametrised CRC-32 engine for the compression unit datapath. It replaces the fixed 32-bit, single-stream CRC register with a configurable-width engine. Each of NCH independent channels keeps its own running CRC, so interleaved compressed streams can be checksummed on one shared datapath. Frames are delimited by start/end flags, partial tail words are supported, and each frame result is returned through a valid/ready output stage.

---
 rtl/crc_mc.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/crc_mc.sv
// crc_mc: multi-channel CRC-32 engine with per-channel running state,
// frame delimiting, partial tail words and a valid/ready result stage.
// Optional feature macro: CRC_CHECK_EN (adds exp_crc input and crc_err flag).
module crc_mc #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NCH    = 4,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] SEED   = 32'h52325032,
  parameter logic [31:0] XOROUT = 32'h00000000,
  localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned NBW   = $clog2(DW / 8) + 1
) (
  input  logic            clk,
  input  logic            crc_rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_ch,
  input  logic            in_sof,
  input  logic            in_eof,
  input  logic [NBW-1:0]  in_nbytes,
  input  logic [DW-1:0]   data_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_ch,
  output logic [31:0]     crc_out
`ifdef CRC_CHECK_EN
  ,
  input  logic [31:0]     exp_crc,
  output logic            crc_err
`endif
);

  localparam int unsigned NB = DW / 8;

  logic [31:0]    st_q [NCH];
  logic [31:0]    st_d [NCH];
  logic           out_valid_q, out_valid_d;
  logic [CW-1:0]  out_ch_q, out_ch_d;
  logic [31:0]    crc_out_q, crc_out_d;
`ifdef CRC_CHECK_EN
  logic           crc_err_q, crc_err_d;
`endif

  logic           accept_c;
  logic           ch_ok_c;
  logic [31:0]    base_c;
  logic [31:0]    new_c;
  logic [NBW-1:0] nproc_c;

  // One byte of MSB-first, non-reflected CRC division.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ b[i]) c = {c[30:0], 1'b0} ^ POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Backpressure is global: a pending result blocks every channel.
  assign in_ready = !out_valid_q || out_ready;
  assign accept_c = in_valid && in_ready;

  // Channel decode and base value; out-of-range channels are flagged invalid.
  always_comb begin
    ch_ok_c = 1'b0;
    base_c  = SEED;
    for (int c = 0; c < NCH; c++) begin
      if (in_ch == CW'(c)) begin
        ch_ok_c = 1'b1;
        if (!in_sof) base_c = st_q[c];
      end
    end
  end

  // Number of lanes to fold in: full word, or clamped tail count on eof.
  always_comb begin
    nproc_c = NBW'(NB);
    if (in_eof && (in_nbytes < NBW'(NB))) nproc_c = in_nbytes;
  end

  // Byte-serial CRC over the processed lanes, top lane first.
  always_comb begin
    new_c = base_c;
    for (int k = 0; k < NB; k++) begin
      if (NBW'(k) < nproc_c) new_c = crc_byte(new_c, data_in[DW-1-8*k -: 8]);
    end
  end

  // Next-state for channel state and the result register.
  always_comb begin
    st_d        = st_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    crc_out_d   = crc_out_q;
`ifdef CRC_CHECK_EN
    crc_err_d   = crc_err_q;
`endif
    if (out_ready) out_valid_d = 1'b0;
    if (accept_c && ch_ok_c) begin
      for (int c = 0; c < NCH; c++) begin
        if (in_ch == CW'(c)) st_d[c] = in_eof ? SEED : new_c;
      end
      if (in_eof) begin
        out_valid_d = 1'b1;
        out_ch_d    = in_ch;
        crc_out_d   = new_c ^ XOROUT;
`ifdef CRC_CHECK_EN
        crc_err_d   = ((new_c ^ XOROUT) != exp_crc);
`endif
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!crc_rst_n) begin
      for (int c = 0; c < NCH; c++) st_q[c] <= SEED;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      crc_out_q   <= '0;
`ifdef CRC_CHECK_EN
      crc_err_q   <= 1'b0;
`endif
    end else begin
      st_q        <= st_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      crc_out_q   <= crc_out_d;
`ifdef CRC_CHECK_EN
      crc_err_q   <= crc_err_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign crc_out   = crc_out_q;
`ifdef CRC_CHECK_EN
  assign crc_err   = crc_err_q;
`endif

endmodule
